// File: rtl/branch_pred_unit_pkg.sv
// Shared decode constants and counter helpers for the Decode-stage branch unit.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
// Contents: MIPS opcode/rt encodings for the conditional branches, 2-bit
//           saturating counter encodings and the counter step function.
package branch_pred_unit_pkg;

  // Primary opcode field values for the conditional branches.
  localparam logic [5:0] OP_SPEC_B = 6'b000001;  // REGIMM: the rt field selects the branch
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  // rt field values under REGIMM. Bit 4 set means "and link".
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  // Bimodal counter encodings. The prediction is the MSB of the counter.
  typedef logic [1:0] ctr_t;
  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  // Step a counter toward the resolved outcome, saturating at both ends.
  function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
    ctr_t nxt;
    nxt = cur;
    if (taken) begin
      if (cur != CTR_ST) nxt = cur + 2'd1;
    end else begin
      if (cur != CTR_SNT) nxt = cur - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_pred_unit_cond.sv
// Decodes op/rt into one of the eight conditional branches and evaluates its condition.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the outputs follow the inputs with no handshake.
// Ports: op, rt (instruction fields), a, b (forwarded rs/rt operands) ->
//        is_branch, taken (condition true), link (BGEZAL/BLTZAL).
module branch_cond_eval
  import branch_pred_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        op,
  input  logic [4:0]        rt,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              is_branch,
  output logic              taken,
  output logic              link
);

  // Sign and zero tests on a are all the single-operand branches need.
  logic a_neg;
  logic a_zero;

  assign a_neg  = a[DATA_W-1];
  assign a_zero = (a == '0);

  always_comb begin
    is_branch = 1'b0;
    taken     = 1'b0;
    link      = 1'b0;
    case (op)
      OP_BEQ: begin
        is_branch = 1'b1;
        taken     = (a == b);
      end
      OP_BNE: begin
        is_branch = 1'b1;
        taken     = (a != b);
      end
      OP_BGTZ: begin
        is_branch = 1'b1;
        taken     = !a_neg && !a_zero;
      end
      OP_BLEZ: begin
        is_branch = 1'b1;
        taken     = a_neg || a_zero;
      end
      OP_SPEC_B: begin
        case (rt)
          RT_BGEZ, RT_BGEZAL: begin
            is_branch = 1'b1;
            taken     = !a_neg;
            link      = (rt == RT_BGEZAL);
          end
          RT_BLTZ, RT_BLTZAL: begin
            is_branch = 1'b1;
            taken     = a_neg;
            link      = (rt == RT_BLTZAL);
          end
          default: begin
            // Other REGIMM encodings (traps, etc.) are not branches here.
            is_branch = 1'b0;
          end
        endcase
      end
      default: begin
        is_branch = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_pred_unit.sv
// Decode-stage branch resolver with a bimodal 2-bit counter table predicting for Fetch.
// Latency: prediction and condition are combinational; resolve report and stats are one cycle after fire.
// Backpressure: stall_d holds a branch back; it fires once, in its first unstalled valid cycle.
// Ports: pc_f -> pred_taken_f (Fetch side); valid_d, stall_d, pc_d, pred_taken_d, op, rt, a, b
//        -> is_branch_d, taken_d, link_d (Decode side); resolve_valid, mispredict, resolve_pc,
//        br_cnt, mis_cnt (registered report to the hazard unit and statistics).
module branch_pred_unit
  import branch_pred_unit_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,   // power of two, >= 2
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [PC_W-1:0]   pc_f,
  output logic              pred_taken_f,

  input  logic              valid_d,
  input  logic              stall_d,
  input  logic [PC_W-1:0]   pc_d,
  input  logic              pred_taken_d,
  input  logic [5:0]        op,
  input  logic [4:0]        rt,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              is_branch_d,
  output logic              taken_d,
  output logic              link_d,

  output logic              resolve_valid,
  output logic              mispredict,
  output logic [PC_W-1:0]   resolve_pc,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  mis_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  ctr_t             bht [BHT_DEPTH];
  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_d;
  logic             fire;
  logic             mis_now;

  branch_cond_eval #(
    .DATA_W (DATA_W)
  ) u_cond (
    .op        (op),
    .rt        (rt),
    .a         (a),
    .b         (b),
    .is_branch (is_branch_d),
    .taken     (taken_d),
    .link      (link_d)
  );

  // Word-aligned index: the two byte-offset bits are dropped, upper PC bits alias.
  assign idx_f = pc_f[IDX_W+1:2];
  assign idx_d = pc_d[IDX_W+1:2];

  // Read straight from the array: a same-cycle update to this entry is not
  // forwarded, so Fetch sees the pre-update counter until the next cycle.
  assign pred_taken_f = bht[idx_f][1];

  assign fire    = valid_d && !stall_d && is_branch_d;
  assign mis_now = (taken_d != pred_taken_d);

  // PC bits outside the index only matter for resolve_pc; fold them here so
  // the intentional drop is visible.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_f[PC_W-1:IDX_W+2], pc_f[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= CTR_WNT;
      end
    end else if (fire) begin
      bht[idx_d] <= ctr_next(bht[idx_d], taken_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resolve_valid <= 1'b0;
      mispredict    <= 1'b0;
      resolve_pc    <= '0;
      br_cnt        <= '0;
      mis_cnt       <= '0;
    end else begin
      resolve_valid <= fire;
      mispredict    <= fire && mis_now;
      if (fire) begin
        resolve_pc <= pc_d;
        if (br_cnt != '1) br_cnt <= br_cnt + 1'b1;
        if (mis_now && (mis_cnt != '1)) mis_cnt <= mis_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_pred_unit.sv
// Scoreboard bench for branch_pred_unit: stimulus pushes expected reports, a monitor pops them.
// Latency: expects each resolve report one cycle after its fire.
// Backpressure: exercises stall_d holding a branch for several cycles.
module tb_branch_pred_unit;

  localparam int DW = 32;
  localparam int PW = 32;
  localparam int D  = 64;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PW-1:0] pc_f = '0;
  logic          pred_taken_f;
  logic          valid_d = 1'b0;
  logic          stall_d = 1'b0;
  logic [PW-1:0] pc_d = '0;
  logic          pred_taken_d = 1'b0;
  logic [5:0]    op = '0;
  logic [4:0]    rt = '0;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          is_branch_d, taken_d, link_d;
  logic          resolve_valid, mispredict;
  logic [PW-1:0] resolve_pc;
  logic [CW-1:0] br_cnt, mis_cnt;

  always #5 clk = ~clk;

  branch_pred_unit #(
    .DATA_W(DW), .PC_W(PW), .BHT_DEPTH(D), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .pc_f(pc_f), .pred_taken_f(pred_taken_f),
    .valid_d(valid_d), .stall_d(stall_d), .pc_d(pc_d), .pred_taken_d(pred_taken_d),
    .op(op), .rt(rt), .a(a), .b(b),
    .is_branch_d(is_branch_d), .taken_d(taken_d), .link_d(link_d),
    .resolve_valid(resolve_valid), .mispredict(mispredict), .resolve_pc(resolve_pc),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  typedef struct {
    bit            mis;
    logic [PW-1:0] pc;
    logic [CW-1:0] bc;
    logic [CW-1:0] mc;
  } rep_t;

  rep_t          q[$];
  int            checks = 0;
  int            failures = 0;
  int            mt[D];          // reference counters, plain integers 0..3
  logic [CW-1:0] m_br = '0;
  logic [CW-1:0] m_mis = '0;
  bit            mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Branch semantics straight from the ISA description, using signed compares.
  function automatic void ref_cond(input logic [5:0] o, input logic [4:0] r,
                                   input logic [31:0] x, input logic [31:0] y,
                                   output bit isb, output bit tk, output bit lk);
    isb = 0; tk = 0; lk = 0;
    case (o)
      6'd4: begin isb = 1; tk = (x == y); end
      6'd5: begin isb = 1; tk = (x != y); end
      6'd7: begin isb = 1; tk = ($signed(x) > 0); end
      6'd6: begin isb = 1; tk = ($signed(x) <= 0); end
      6'd1: begin
        if (r == 5'd0 || r == 5'd16) begin
          isb = 1; tk = ($signed(x) < 0); lk = (r == 5'd16);
        end else if (r == 5'd1 || r == 5'd17) begin
          isb = 1; tk = ($signed(x) >= 0); lk = (r == 5'd17);
        end
      end
      default: ;
    endcase
  endfunction

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % D);
  endfunction

  // One Decode/Fetch cycle: drive, check combinational outputs, predict the edge.
  task automatic step(input bit r, input bit v, input bit s, input logic [31:0] pcd,
                      input bit pd, input logic [5:0] o, input logic [4:0] t,
                      input logic [31:0] x, input logic [31:0] y, input logic [31:0] pcf);
    bit isb, tk, lk, fire, mis;
    int k;
    @(negedge clk);
    rst = r; valid_d = v; stall_d = s; pc_d = pcd; pred_taken_d = pd;
    op = o; rt = t; a = x; b = y; pc_f = pcf;
    #1;
    ref_cond(o, t, x, y, isb, tk, lk);
    if (mon_en) begin
      chk("is_branch_d", 64'(is_branch_d), 64'(isb));
      chk("taken_d", 64'(taken_d), 64'(tk));
      chk("link_d", 64'(link_d), 64'(lk));
      chk("pred_taken_f", 64'(pred_taken_f), 64'(mt[midx(pcf)] >= 2));
    end
    if (r) mon_en = 1'b1;
    fire = v && !s && isb;
    if (r) begin
      for (int i = 0; i < D; i++) mt[i] = 1;
      m_br = '0;
      m_mis = '0;
    end else if (fire) begin
      mis = (tk != pd);
      if (m_br != '1) m_br = m_br + 1;
      if (mis && m_mis != '1) m_mis = m_mis + 1;
      q.push_back('{mis, pcd, m_br, m_mis});
      k = midx(pcd);
      mt[k] = tk ? ((mt[k] == 3) ? 3 : mt[k] + 1) : ((mt[k] == 0) ? 0 : mt[k] - 1);
    end
  endtask

  task automatic idle(input logic [31:0] pcf);
    step(0, 0, 0, 32'h0, 0, 6'd0, 5'd0, 32'h0, 32'h0, pcf);
  endtask

  // Monitor: one report per fire, exactly one cycle later; nothing otherwise.
  initial begin
    logic [PW-1:0] last_pc;
    bit            rr;
    rep_t          e;
    last_pc = '0;
    forever begin
      @(posedge clk);
      rr = rst;
      #1;
      if (mon_en) begin
        if (rr) begin
          chk("rst_resolve_valid", 64'(resolve_valid), 64'(0));
          chk("rst_mispredict", 64'(mispredict), 64'(0));
          chk("rst_resolve_pc", 64'(resolve_pc), 64'(0));
          chk("rst_br_cnt", 64'(br_cnt), 64'(0));
          chk("rst_mis_cnt", 64'(mis_cnt), 64'(0));
          last_pc = '0;
        end else if (q.size() > 0) begin
          e = q.pop_front();
          chk("resolve_valid", 64'(resolve_valid), 64'(1));
          chk("mispredict", 64'(mispredict), 64'(e.mis));
          chk("resolve_pc", 64'(resolve_pc), 64'(e.pc));
          chk("br_cnt", 64'(br_cnt), 64'(e.bc));
          chk("mis_cnt", 64'(mis_cnt), 64'(e.mc));
          last_pc = e.pc;
        end else begin
          chk("idle_resolve_valid", 64'(resolve_valid), 64'(0));
          chk("idle_mispredict", 64'(mispredict), 64'(0));
          chk("hold_resolve_pc", 64'(resolve_pc), 64'(last_pc));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0]  ro;
    logic [4:0]  rrt;
    logic [31:0] ra, rb, rpc;
    logic [31:0] bvals [6];
    bvals[0] = 32'h0; bvals[1] = 32'h1; bvals[2] = 32'hFFFF_FFFF;
    bvals[3] = 32'h8000_0000; bvals[4] = 32'h7FFF_FFFF; bvals[5] = 32'h5;

    step(1, 0, 0, 32'h0, 0, 6'd0, 5'd0, 32'h0, 32'h0, 32'h0040_0000);
    // Every entry reads weakly not-taken after reset.
    for (int i = 0; i < D; i++) idle(32'h0040_0000 + 32'(4 * i));

    // BEQ taken, predicted not-taken: mispredict, entry moves to weakly taken.
    step(0, 1, 0, 32'h0040_0010, 0, 6'd4, 5'd0, 32'd5, 32'd5, 32'h0040_0010);
    idle(32'h0040_0010);

    // Signed boundaries and decode-only cases (valid_d low: no fire).
    step(0, 0, 0, 32'h0, 0, 6'd7, 5'd0, 32'h0, 32'h0, 32'h0);
    step(0, 0, 0, 32'h0, 0, 6'd6, 5'd0, 32'h8000_0000, 32'h0, 32'h0);
    step(0, 0, 0, 32'h0, 0, 6'd1, 5'd1, 32'h0, 32'h0, 32'h0);
    step(0, 0, 0, 32'h0, 0, 6'd1, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    step(0, 0, 0, 32'h0, 0, 6'd1, 5'd16, 32'h1, 32'h0, 32'h0);
    step(0, 1, 0, 32'h0, 0, 6'd1, 5'd2, 32'h1, 32'h0, 32'h0);

    // Saturation at one PC; pc_f on the same entry also checks the no-bypass read.
    for (int i = 0; i < 4; i++)
      step(0, 1, 0, 32'h0040_0020, 1, 6'd4, 5'd0, 32'd7, 32'd7, 32'h0040_0020);
    step(0, 1, 0, 32'h0040_0020, 1, 6'd5, 5'd0, 32'd7, 32'd7, 32'h0040_0020);
    step(0, 1, 0, 32'h0040_0020, 1, 6'd5, 5'd0, 32'd7, 32'd7, 32'h0040_0020);
    idle(32'h0040_0020);

    // A stalled BNE fires once, when the stall drops.
    for (int i = 0; i < 3; i++)
      step(0, 1, 1, 32'h0040_0030, 0, 6'd5, 5'd0, 32'd1, 32'd2, 32'h0040_0030);
    step(0, 1, 0, 32'h0040_0030, 0, 6'd5, 5'd0, 32'd1, 32'd2, 32'h0040_0030);
    idle(32'h0040_0030);

    // 0x0 and 0x100 share entry 0.
    step(0, 1, 0, 32'h0, 0, 6'd4, 5'd0, 32'd3, 32'd3, 32'h100);
    step(0, 1, 0, 32'h0, 1, 6'd4, 5'd0, 32'd3, 32'd3, 32'h100);
    idle(32'h100);

    // Reset mid-stream with a fire in the reset cycle: discarded.
    step(0, 1, 0, 32'h0040_0040, 0, 6'd4, 5'd0, 32'd1, 32'd1, 32'h0040_0040);
    step(1, 1, 0, 32'h0040_0040, 0, 6'd4, 5'd0, 32'd1, 32'd1, 32'h0040_0040);
    idle(32'h0040_0040);
    idle(32'h0);

    // Randomized traffic with aliasing-prone PCs, boundary operands and stalls.
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 6))
        0: ro = 6'd4;
        1: ro = 6'd5;
        2: ro = 6'd6;
        3: ro = 6'd7;
        4, 5: ro = 6'd1;
        default: ro = 6'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0: rrt = 5'd0;
        1: rrt = 5'd1;
        2: rrt = 5'd16;
        3: rrt = 5'd17;
        default: rrt = 5'($urandom);
      endcase
      ra = ($urandom_range(0, 1) == 0) ? bvals[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 1) == 0) ? ra : bvals[$urandom_range(0, 5)];
      rpc = {($urandom_range(0, 1) == 0) ? 24'h004000 : 24'($urandom), 6'($urandom), 2'b00};
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) == 0), rpc, 1'($urandom), ro, rrt, ra, rb,
           ($urandom_range(0, 1) == 0) ? rpc : {24'h004000, 6'($urandom), 2'b00});
    end
    idle(32'h0);
    idle(32'h0);
    chk("queue_drained", 64'(q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
